// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/handshake bundle between multicycle_controller and its datapath
//
// Signals:
//   opcode      IR[6:0] from the datapath
//   mem_ready   memory access completes this cycle
//   pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write  datapath strobes
//   alu_src_a, alu_src_b, alu_op, result_src                             datapath selects
//   state, trap, trap_cause, instret                                     status / debug
// Modports: master = controller, slave = datapath side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             branch;
  logic             ir_write;
  logic             adr_src;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       result_src;
  logic [3:0]       state;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, mem_ready,
    output pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, state, trap, trap_cause, instret
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, state, trap, trap_cause, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FSM sequencing a shared-resource multicycle RV32I datapath
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    multicycle_controller_if.master: opcode/mem_ready in, strobes, selects and status out
// Parameters:
//   MEM_TIMEOUT  max wait cycles for mem_ready per access (0 disables the watchdog)
//   CNT_W        width of the retired-instruction counter
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [1:0]         nxt_cause;
  logic [1:0]         cause_q;
  logic [WAIT_W-1:0]  wcnt;
  logic [CNT_W-1:0]   instret_q;
  logic               waiting;
  logic               timeout;
  logic               retire;

  always_comb begin
    waiting   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    // A ready on the timeout cycle wins, so the watchdog only fires while ready is low.
    timeout   = waiting && !bus.mem_ready && (MEM_TIMEOUT != 0) &&
                (wcnt == WAIT_W'(MEM_TIMEOUT));
    retire    = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                (state == S_ALUWB) || (state == S_BRANCH);
    nxt       = state;
    nxt_cause = 2'b00;
    case (state)
      S_FETCH:    if (bus.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_BR:        nxt = S_BRANCH;
          OP_JAL:       nxt = S_JAL;
          OP_JALR:      nxt = S_JALR;
          default: begin
            nxt       = S_TRAP;
            nxt_cause = 2'b01;
          end
        endcase
      end
      S_MEMADR:   nxt = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_JALR:     nxt = S_JAL;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
    if (timeout) begin
      nxt       = S_TRAP;
      nxt_cause = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      wcnt      <= '0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)
        wcnt <= '0;
      else if (waiting && !bus.mem_ready)
        wcnt <= wcnt + WAIT_W'(1);
      if ((nxt == S_TRAP) && (state != S_TRAP))
        cause_q <= nxt_cause;
      if (retire && (nxt == S_FETCH))
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Strobes are decoded from the registered state and gated by reset so a pending
  // memory request disappears the moment reset is asserted.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.result_src = 2'b00;
    bus.trap       = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          bus.mem_read   = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
        end
        S_MEMADR, S_JALR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          bus.mem_read = 1'b1;
          bus.adr_src  = 1'b1;
        end
        S_MEMWB: begin
          bus.result_src = 2'b01;
          bus.reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_write = 1'b1;
          bus.adr_src   = 1'b1;
        end
        S_EXECR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_op    = 2'b10;
        end
        S_EXECI: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
          bus.alu_op    = 2'b10;
        end
        S_ALUWB:  bus.reg_write = 1'b1;
        S_BRANCH: begin
          bus.alu_src_a = 2'b10;
          bus.alu_op    = 2'b01;
          bus.branch    = 1'b1;
        end
        S_JAL: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.pc_write  = 1'b1;
        end
        S_TRAP:  bus.trap = 1'b1;
        default: bus.trap = 1'b0;
      endcase
    end
  end

  assign bus.state      = state;
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy FSM that sequences a shared-resource multicycle RV32I datapath: one memory port, one ALU, one register file.
- Decodes the 7-bit opcode held in the external instruction register (IR) and steps each instruction through fetch, decode, execute, memory and writeback states.
- Supports variable-latency memory through a ready handshake, with a timeout watchdog.
- Provides an illegal-opcode trap and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready per access; 0 disables the timeout.
- CNT_W, 32, width of instret.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC update.
- branch  out  1  conditional PC update; datapath uses pc_en = pc_write | (branch & zero).
- ir_write  out  1  load IR and oldPC.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  ALU operand A: 00 = PC, 01 = oldPC, 10 = rs1.
- alu_src_b  out  2  ALU operand B: 00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- result_src  out  2  writeback/PC source: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- state  out  4  current state code, for debug.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = FETCH.
  - trap = 0, trap_cause = 00, instret = 0, wait counter = 0.
  - Every output listed below as zero when not asserted is driven 0 during reset.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, TRAP 12.
- Per-state outputs (anything not listed is 0):
  - FETCH: mem_read=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=pc_write=mem_ready (Mealy). Stay while !mem_ready; go to DECODE on mem_ready.
  - DECODE: a=01, b=01, alu_op=00 (branch/JAL target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - any other opcode -> TRAP with cause 01
  - MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD if opcode is LW, else MEMWRITE.
  - MEMREAD: mem_read=1, adr_src=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: result_src=01, reg_write=1. Go to FETCH.
  - MEMWRITE: mem_write=1, adr_src=1. Hold until mem_ready, then go to FETCH.
  - EXECR: a=10, b=00, alu_op=10. Go to ALUWB.
  - EXECI: a=10, b=01, alu_op=10. Go to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Go to FETCH.
  - BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1. Go to FETCH.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1 (PC <- target, ALU computes oldPC+4). Go to ALUWB.
  - JALR: a=10, b=01, alu_op=00 (rs1+imm into ALUOut). Go to JAL.
  - TRAP: trap=1, all strobes 0. Terminal; only reset exits.
- Latency when memory is ready immediately:
  - R/I type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BRANCH: 3 cycles.
  - JAL: 4 cycles.
  - JALR: 5 cycles.
- Handshake rules:
  - mem_read and mem_write stay stable while waiting.
  - mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- Wait counter:
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on any state change.
  - If MEM_TIMEOUT != 0 and the counter equals MEM_TIMEOUT while mem_ready is still 0, next state = TRAP with cause 10.
  - mem_ready=1 on the same cycle as the timeout wins: the access completes.
- instret:
  - +1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Wraps modulo 2^CNT_W.
  - Never increments in TRAP or after reset.
- trap_cause latches on entry to TRAP and holds until reset.
- Reset asserted mid-instruction: immediate return to FETCH; a pending memory request is dropped the same cycle.

Test Plan:
- R-type: opcode=0110011, mem_ready=1 -> states 0,1,6,8,0; reg_write=1 only in ALUWB; instret 0->1.
- LW with 3 wait cycles in MEMREAD: mem_read=1 and adr_src=1 held for 4 cycles -> MEMWB with result_src=01, reg_write=1; total 8 cycles; instret=1.
- BEQ then JALR: branch=1 for exactly one cycle in state 9. JALR visits 11,10,8 with pc_write=1 only in state 10; instret=2 after both.
- Illegal opcode 7'b1111111: DECODE -> TRAP; trap=1, trap_cause=01; remains in state 12 for 20 cycles regardless of mem_ready; instret unchanged.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after the counter reaches 4, trap_cause=10. Repeat with mem_ready=1 on that cycle -> DECODE, no trap.
- Reset pulse asserted in MEMWRITE with mem_write=1 -> mem_write drops asynchronously, state=0, instret=0. CNT_W=4 with 16 retired instructions -> instret wraps to 0.
